// File: rtl/nios_dbg_cmd_bridge.sv
// nios_dbg_cmd_bridge
// Sysclk-side bridge for the Nios II JTAG debug slave. Synchronises the
// virtual-JTAG update levels, queues each update-DR command ({ir, sr}) in a
// small show-ahead FIFO and replays it as jdo/jir plus a one-hot
// take_action / take_no_action pulse under a valid/ready handshake.
// Update-IR edges bypass the FIFO and simply latch ir_in into ir_cur.
module nios_dbg_cmd_bridge #(
    parameter  int SR_W        = 38,
    parameter  int IR_W        = 2,
    parameter  int ACT_BIT     = 35,
    parameter  int SYNC_STAGES = 2,
    parameter  int FIFO_DEPTH  = 4,
    localparam int N_CH        = 2 ** IR_W,
    localparam int PTR_W       = $clog2(FIFO_DEPTH),
    localparam int LVL_W       = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [SR_W-1:0]   sr,
    input  logic [IR_W-1:0]   ir_in,
    input  logic              vs_udr,
    input  logic              vs_uir,
    input  logic              cmd_ready,
    input  logic              clear_ovf,
    output logic              cmd_valid,
    output logic [SR_W-1:0]   jdo,
    output logic [IR_W-1:0]   jir,
    output logic [N_CH-1:0]   take_action,
    output logic [N_CH-1:0]   take_no_action,
    output logic              ir_strobe,
    output logic [IR_W-1:0]   ir_cur,
    output logic              overflow,
    output logic [LVL_W-1:0]  fifo_level
);

    localparam int ENT_W = IR_W + SR_W;

    // Synchroniser chains and the previous synchronised level for edge detect
    logic [SYNC_STAGES-1:0] udr_sync_q;
    logic [SYNC_STAGES-1:0] uir_sync_q;
    logic                   udr_prev_q;
    logic                   uir_prev_q;
    logic                   udr_edge;
    logic                   uir_edge;

    // Command storage; entries carry {ir, sr}
    logic [ENT_W-1:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic                   overflow_q, overflow_d;

    // Replay and IR outputs
    logic [SR_W-1:0]        jdo_q, jdo_d;
    logic [IR_W-1:0]        jir_q, jir_d;
    logic [N_CH-1:0]        ta_q, ta_d;
    logic [N_CH-1:0]        tna_q, tna_d;
    logic                   ir_strobe_q, ir_strobe_d;
    logic [IR_W-1:0]        ir_cur_q, ir_cur_d;

    logic                   full;
    logic                   pop;
    logic                   accept;
    logic [ENT_W-1:0]       head;
    logic [SR_W-1:0]        head_sr;
    logic [IR_W-1:0]        head_ir;
    logic [N_CH-1:0]        head_onehot;

    // A level that is already high when reset releases still produces one
    // edge because the previous-level flops restart at 0.
    assign udr_edge = udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q;
    assign uir_edge = uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q;

    assign full        = (level_q == LVL_W'(FIFO_DEPTH));
    assign cmd_valid   = (level_q != '0);
    assign pop         = cmd_valid & cmd_ready;
    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign accept      = udr_edge & (~full | pop);
    assign head        = mem_q[rd_ptr_q];
    assign head_sr     = head[SR_W-1:0];
    assign head_ir     = head[ENT_W-1:SR_W];
    assign head_onehot = N_CH'(1) << head_ir;

    // Bring the asynchronous update levels into clk and keep the last level seen
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync_q <= '0;
            uir_sync_q <= '0;
            udr_prev_q <= 1'b0;
            uir_prev_q <= 1'b0;
        end else begin
            udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
            uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
            udr_prev_q <= udr_sync_q[SYNC_STAGES-1];
            uir_prev_q <= uir_sync_q[SYNC_STAGES-1];
        end
    end

    // Command storage is plain data; the pointers decide what is meaningful
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= {ir_in, sr};
        end
    end

    // Next-state for FIFO bookkeeping, overflow flag, replay and IR latch
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        jdo_d       = jdo_q;
        jir_d       = jir_q;
        ta_d        = '0;
        tna_d       = '0;
        ir_strobe_d = uir_edge;
        ir_cur_d    = ir_cur_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            jdo_d    = head_sr;
            jir_d    = head_ir;
            if (head_sr[ACT_BIT]) begin
                ta_d = head_onehot;
            end else begin
                tna_d = head_onehot;
            end
        end

        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        level_d = level_q + LVL_W'(accept) - LVL_W'(pop);

        // Setting beats clearing so a drop is never lost.
        if (udr_edge & full & ~pop) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end

        if (uir_edge) begin
            ir_cur_d = ir_in;
        end
    end

    // State registers; reset flushes every queued command and all outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            jdo_q       <= '0;
            jir_q       <= '0;
            ta_q        <= '0;
            tna_q       <= '0;
            ir_strobe_q <= 1'b0;
            ir_cur_q    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            jdo_q       <= jdo_d;
            jir_q       <= jir_d;
            ta_q        <= ta_d;
            tna_q       <= tna_d;
            ir_strobe_q <= ir_strobe_d;
            ir_cur_q    <= ir_cur_d;
        end
    end

    assign jdo            = jdo_q;
    assign jir            = jir_q;
    assign take_action    = ta_q;
    assign take_no_action = tna_q;
    assign ir_strobe      = ir_strobe_q;
    assign ir_cur         = ir_cur_q;
    assign overflow       = overflow_q;
    assign fifo_level     = level_q;

endmodule

// File: tb/tb_nios_dbg_cmd_bridge.sv
// Bench for nios_dbg_cmd_bridge: two instances (default parameters and
// SR_W=46/IR_W=3/SYNC_STAGES=3) share one stimulus stream and are each
// compared every cycle against a queue-style behavioural model.
module tb_nios_dbg_cmd_bridge;

    localparam logic [45:0] B35 = 46'h8_0000_0000;

    logic        clk = 1'b0;
    logic        reset_n, vs_udr, vs_uir, cmd_ready, clear_ovf;
    logic [45:0] sr;
    logic [2:0]  ir_in;

    logic        c0_valid, c0_irs, c0_ovf;
    logic [37:0] c0_jdo;
    logic [1:0]  c0_jir, c0_irc;
    logic [3:0]  c0_ta, c0_tna;
    logic [2:0]  c0_lvl;

    logic        c1_valid, c1_irs, c1_ovf;
    logic [45:0] c1_jdo;
    logic [2:0]  c1_jir, c1_irc;
    logic [7:0]  c1_ta, c1_tna;
    logic [2:0]  c1_lvl;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    nios_dbg_cmd_bridge #(.SR_W(38), .IR_W(2), .ACT_BIT(35), .SYNC_STAGES(2), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .sr(sr[37:0]), .ir_in(ir_in[1:0]),
        .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_ready(cmd_ready), .clear_ovf(clear_ovf),
        .cmd_valid(c0_valid), .jdo(c0_jdo), .jir(c0_jir), .take_action(c0_ta),
        .take_no_action(c0_tna), .ir_strobe(c0_irs), .ir_cur(c0_irc),
        .overflow(c0_ovf), .fifo_level(c0_lvl)
    );

    nios_dbg_cmd_bridge #(.SR_W(46), .IR_W(3), .ACT_BIT(35), .SYNC_STAGES(3), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .sr(sr), .ir_in(ir_in),
        .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_ready(cmd_ready), .clear_ovf(clear_ovf),
        .cmd_valid(c1_valid), .jdo(c1_jdo), .jir(c1_jir), .take_action(c1_ta),
        .take_no_action(c1_tna), .ir_strobe(c1_irs), .ir_cur(c1_irc),
        .overflow(c1_ovf), .fifo_level(c1_lvl)
    );

    // ---------------- behavioural model (index 0 = dut0, 1 = dut1) ----------------
    logic        hu  [2][8];     // vs_udr as sampled at the last 8 edges, [0] newest
    logic        hir [2][8];     // vs_uir likewise
    logic [63:0] q_sr [2][4];    // queued commands, [0] is the oldest
    logic [7:0]  q_ir [2][4];
    int          m_cnt [2];
    logic [63:0] e_jdo [2];
    logic [7:0]  e_jir [2], e_ta [2], e_tna [2], e_irc [2];
    logic        e_irs [2], e_ovf [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        for (int j = 0; j < 8; j++) begin
            hu[i][j]  = 1'b0;
            hir[i][j] = 1'b0;
        end
        for (int j = 0; j < 4; j++) begin
            q_sr[i][j] = '0;
            q_ir[i][j] = '0;
        end
        m_cnt[i] = 0;
        e_jdo[i] = '0; e_jir[i] = '0; e_ta[i] = '0; e_tna[i] = '0;
        e_irc[i] = '0; e_irs[i] = 1'b0; e_ovf[i] = 1'b0;
    endtask

    task automatic model_step(input int i);
        int          s;
        logic [63:0] srm;
        logic [7:0]  irm;
        logic        ue, ie, pop, drop;
        if (!reset_n) begin
            model_reset(i);
            return;
        end
        s   = (i == 0) ? 2 : 3;
        srm = (i == 0) ? {26'd0, sr[37:0]} : {18'd0, sr};
        irm = (i == 0) ? {6'd0, ir_in[1:0]} : {5'd0, ir_in};
        // a command is taken s edges after the first edge that saw the level high
        ue = hu[i][s-1] && !hu[i][s];
        ie = hir[i][s-1] && !hir[i][s];
        for (int j = 7; j > 0; j--) begin
            hu[i][j]  = hu[i][j-1];
            hir[i][j] = hir[i][j-1];
        end
        hu[i][0]  = vs_udr;
        hir[i][0] = vs_uir;

        pop = (m_cnt[i] > 0) && cmd_ready;
        e_ta[i]  = '0;
        e_tna[i] = '0;
        if (pop) begin
            e_jdo[i] = q_sr[i][0];
            e_jir[i] = q_ir[i][0];
            if (q_sr[i][0][35]) e_ta[i]  = 8'(1) << q_ir[i][0];
            else                e_tna[i] = 8'(1) << q_ir[i][0];
            for (int j = 0; j < 3; j++) begin
                q_sr[i][j] = q_sr[i][j+1];
                q_ir[i][j] = q_ir[i][j+1];
            end
            m_cnt[i]--;
        end
        drop = 1'b0;
        if (ue) begin
            if (m_cnt[i] < 4) begin
                q_sr[i][m_cnt[i]] = srm;
                q_ir[i][m_cnt[i]] = irm;
                m_cnt[i]++;
            end else begin
                drop = 1'b1;
            end
        end
        if (drop)           e_ovf[i] = 1'b1;
        else if (clear_ovf) e_ovf[i] = 1'b0;
        e_irs[i] = ie;
        if (ie) e_irc[i] = irm;
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("d0_cmd_valid",  64'(c0_valid), 64'(m_cnt[0] != 0));
            chk("d0_fifo_level", 64'(c0_lvl),   64'(m_cnt[0]));
            chk("d0_jdo",        64'(c0_jdo),   e_jdo[0]);
            chk("d0_jir",        64'(c0_jir),   64'(e_jir[0]));
            chk("d0_take_act",   64'(c0_ta),    64'(e_ta[0]));
            chk("d0_take_noact", 64'(c0_tna),   64'(e_tna[0]));
            chk("d0_ir_strobe",  64'(c0_irs),   64'(e_irs[0]));
            chk("d0_ir_cur",     64'(c0_irc),   64'(e_irc[0]));
            chk("d0_overflow",   64'(c0_ovf),   64'(e_ovf[0]));
            chk("d1_cmd_valid",  64'(c1_valid), 64'(m_cnt[1] != 0));
            chk("d1_fifo_level", 64'(c1_lvl),   64'(m_cnt[1]));
            chk("d1_jdo",        64'(c1_jdo),   e_jdo[1]);
            chk("d1_jir",        64'(c1_jir),   64'(e_jir[1]));
            chk("d1_take_act",   64'(c1_ta),    64'(e_ta[1]));
            chk("d1_take_noact", 64'(c1_tna),   64'(e_tna[1]));
            chk("d1_ir_strobe",  64'(c1_irs),   64'(e_irs[1]));
            chk("d1_ir_cur",     64'(c1_irc),   64'(e_irc[1]));
            chk("d1_overflow",   64'(c1_ovf),   64'(e_ovf[1]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse(input logic [45:0] s, input logic [2:0] ir, input int hi, input int lo);
        sr = s; ir_in = ir; vs_udr = 1'b1;
        repeat (hi) tick();
        vs_udr = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic rtick(input bool_busy);
        cmd_ready = bool_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
        clear_ovf = ($urandom_range(0, 9) == 0);
        vs_uir    = ($urandom_range(0, 3) == 0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n0, nstr, ntna, npl, ns, hi, lo;
        logic [3:0] tna_seen;
        reset_n = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0; cmd_ready = 1'b0;
        clear_ovf = 1'b0; sr = '0; ir_in = '0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_cmd_valid",  64'(c0_valid), 64'd0);
        chk("rst_fifo_level", 64'(c0_lvl),   64'd0);
        chk("rst_jdo",        64'(c0_jdo),   64'd0);
        chk("rst_take",       64'(c0_ta | c0_tna), 64'd0);
        chk("rst_overflow",   64'(c0_ovf),   64'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // T1: single command, latency and one-cycle take_action pulse
        cmd_ready = 1'b1;
        sr = 46'h2A_0000_0055; ir_in = 3'd2; vs_udr = 1'b1;
        tick();                                  // edge k samples the level
        tick();
        chk("T1_valid_k1",    64'(c0_valid), 64'd0);
        tick();
        chk("T1_valid_k2",    64'(c0_valid), 64'd1);
        chk("T1_d1_valid_k2", 64'(c1_valid), 64'd0);
        tick();
        chk("T1_jdo",         64'(c0_jdo), 64'h2A_0000_0055);
        chk("T1_jir",         64'(c0_jir), 64'd2);
        chk("T1_take_action", 64'(c0_ta),  64'b0100);
        chk("T1_d1_valid_k3", 64'(c1_valid), 64'd1);
        tick();
        chk("T1_pulse_end",   64'(c0_ta),  64'd0);
        chk("T1_d1_take",     64'(c1_ta),  64'b0000_0100);
        chk("T1_d1_jdo",      64'(c1_jdo), 64'h2A_0000_0055);
        vs_udr = 1'b0;
        repeat (5) tick();

        // T2: five commands into a depth-4 FIFO, then drain in order
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            pulse(46'h100 + 46'(i) | ((i % 2) ? B35 : 46'd0), 3'(i), 4, 4);
        chk("T2_level",    64'(c0_lvl), 64'd4);
        chk("T2_overflow", 64'(c0_ovf), 64'd1);
        chk("T2_d1_level", 64'(c1_lvl), 64'd4);
        chk("T2_d1_ovf",   64'(c1_ovf), 64'd1);
        cmd_ready = 1'b1;
        n0 = 0;
        repeat (8) begin
            tick();
            if ((c0_ta | c0_tna) != 0) begin
                chk("T2_order", 64'(c0_jdo[7:0]), 64'(n0));
                n0++;
            end
        end
        chk("T2_npulses", 64'(n0), 64'd4);

        // T3: FIFO full, pop and push in the same cycle
        clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) pulse(46'h200 + 46'(i), 3'(i), 4, 4);
        sr = 46'h0_0C0F_FEE0; ir_in = 3'd3; vs_udr = 1'b1;
        tick();
        tick();
        cmd_ready = 1'b1;
        tick();                                  // dut0 pops and pushes here
        cmd_ready = 1'b0;
        chk("T3_level",    64'(c0_lvl), 64'd4);
        chk("T3_overflow", 64'(c0_ovf), 64'd0);
        repeat (2) tick();
        vs_udr = 1'b0;
        repeat (4) tick();
        chk("T3_d1_level", 64'(c1_lvl), 64'd4);
        chk("T3_d1_ovf",   64'(c1_ovf), 64'd0);
        cmd_ready = 1'b1;
        repeat (8) tick();
        chk("T3_last_jdo",    64'(c0_jdo), 64'h0C0F_FEE0);
        chk("T3_d1_last_jdo", 64'(c1_jdo), 64'h0C0F_FEE0);

        // T4: update-IR and update-DR together
        sr = 46'h1234; ir_in = 3'd1; vs_udr = 1'b1; vs_uir = 1'b1;
        nstr = 0; ntna = 0; tna_seen = '0;
        repeat (6) begin
            tick();
            if (c0_irs) nstr++;
            if (c0_tna != 0) begin ntna++; tna_seen = c0_tna; end
        end
        chk("T4_ir_strobes", 64'(nstr), 64'd1);
        chk("T4_ir_cur",     64'(c0_irc), 64'd1);
        chk("T4_ntna",       64'(ntna), 64'd1);
        chk("T4_tna",        64'(tna_seen), 64'b0010);
        vs_udr = 1'b0; vs_uir = 1'b0;
        repeat (4) tick();

        // T5: reset flushes queued commands; a level held across release gives one command
        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) pulse(46'h300 + 46'(i), 3'(i), 4, 4);
        chk("T5_level_pre", 64'(c0_lvl), 64'd3);
        sr = 46'h5A5; ir_in = 3'd1; vs_udr = 1'b1;
        tick();
        reset_n = 1'b0;
        repeat (2) tick();
        chk("T5_valid_rst", 64'(c0_valid), 64'd0);
        chk("T5_level_rst", 64'(c0_lvl),   64'd0);
        chk("T5_d1_level",  64'(c1_lvl),   64'd0);
        reset_n = 1'b1;
        npl = 0;
        repeat (7) begin
            tick();
            if ((c0_ta | c0_tna) != 0) npl++;
        end
        chk("T5_no_pulse",    64'(npl),    64'd0);
        chk("T5_one_cmd",     64'(c0_lvl), 64'd1);
        chk("T5_d1_one_cmd",  64'(c1_lvl), 64'd1);
        vs_udr = 1'b0;
        repeat (4) tick();
        cmd_ready = 1'b1;
        repeat (4) tick();
        chk("T5_jdo", 64'(c0_jdo), 64'h5A5);

        // T6: walking ir on the wide instance
        for (int ir = 0; ir < 8; ir++) begin
            sr = ((ir % 2 == 0) ? B35 : 46'd0) | 46'(ir);
            ir_in = 3'(ir);
            ns = 0;
            for (int t = 0; t < 8; t++) begin
                vs_udr = (t < 4);
                tick();
                if ((c1_ta | c1_tna) != 0) begin
                    ns++;
                    chk("T6_bit",  64'(c1_ta | c1_tna), 64'(8'(1) << ir));
                    chk("T6_kind", 64'(c1_ta != 0),     64'(ir % 2 == 0));
                end
            end
            chk("T6_count", 64'(ns), 64'd1);
        end

        // Random traffic: random commands, ready, clears and IR updates
        for (int p = 0; p < 160; p++) begin
            if (p == 80) begin
                reset_n = 1'b0;
                repeat (2) tick();
                reset_n = 1'b1;
            end
            sr    = {14'($urandom), 32'($urandom)};
            ir_in = 3'($urandom_range(0, 7));
            hi    = $urandom_range(1, 4);
            lo    = ((5 - hi) > 1 ? (5 - hi) : 1) + $urandom_range(0, 3);
            vs_udr = 1'b1;
            repeat (hi) rtick(p >= 80);
            vs_udr = 1'b0;
            repeat (lo) rtick(p >= 80);
        end
        cmd_ready = 1'b1; clear_ovf = 1'b0; vs_uir = 1'b0;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
